// File: rtl/io_stream_loader.sv
// Pad-side loader: captures the configuration words, then assembles 16-bit half-words
// into 32-bit instruction and data memory writes, with batched data handed off via done/ack.
module io_stream_loader #(
    parameter int IN_WIDTH    = 16,
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_CONFIGS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [ADDR_WIDTH-1:0] instr_max_wadr,
    output logic [ADDR_WIDTH-1:0] input_max_wadr,
    output logic [ADDR_WIDTH-1:0] input_wadr_offset,
    output logic [ADDR_WIDTH-1:0] output_max_adr,
    output logic [ADDR_WIDTH-1:0] output_adr_offset,
    output logic                  config_done,
    output logic                  instr_wen,
    output logic [ADDR_WIDTH-1:0] instr_wadr,
    output logic [WORD_WIDTH-1:0] instr_wdata,
    output logic                  data_wen,
    output logic [ADDR_WIDTH-1:0] data_wadr,
    output logic [WORD_WIDTH-1:0] data_wdata,
    output logic                  instr_done,
    output logic                  batch_done,
    input  logic                  batch_ack
);

    localparam logic [1:0] ST_CFG   = 2'd0;
    localparam logic [1:0] ST_INSTR = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam int CNT_W = $clog2(NUM_CONFIGS);
    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(NUM_CONFIGS - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cfg_cnt;
    logic [ADDR_WIDTH-1:0] cfg_regs [NUM_CONFIGS];
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  half;
    logic [IN_WIDTH-1:0]   low_half;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] region_max;
    logic                  last_word;

    assign xfer       = in_vld && in_rdy;
    assign region_max = (state == ST_INSTR) ? cfg_regs[0] : cfg_regs[1];
    assign last_word  = (word_cnt == region_max);

    assign instr_max_wadr    = cfg_regs[0];
    assign input_max_wadr    = cfg_regs[1];
    assign input_wadr_offset = cfg_regs[2];
    assign output_max_adr    = cfg_regs[3];
    assign output_adr_offset = cfg_regs[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONFIGS; i++) begin
                cfg_regs[i] <= '0;
            end
        end else if (state == ST_CFG && xfer) begin
            cfg_regs[cfg_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CFG;
            cfg_cnt     <= '0;
            word_cnt    <= '0;
            half        <= 1'b0;
            low_half    <= '0;
            in_rdy      <= 1'b0;
            config_done <= 1'b0;
            instr_done  <= 1'b0;
            batch_done  <= 1'b0;
            instr_wen   <= 1'b0;
            instr_wadr  <= '0;
            instr_wdata <= '0;
            data_wen    <= 1'b0;
            data_wadr   <= '0;
            data_wdata  <= '0;
        end else begin
            instr_wen <= 1'b0;
            data_wen  <= 1'b0;
            in_rdy    <= (state != ST_WAIT);
            case (state)
                ST_CFG: begin
                    if (xfer) begin
                        if (cfg_cnt == CFG_LAST) begin
                            config_done <= 1'b1;
                            cfg_cnt     <= '0;
                            word_cnt    <= '0;
                            half        <= 1'b0;
                            state       <= ST_INSTR;
                        end else begin
                            cfg_cnt <= cfg_cnt + 1'b1;
                        end
                    end
                end
                ST_INSTR, ST_DATA: begin
                    if (xfer && !half) begin
                        low_half <= in_data;
                        half     <= 1'b1;
                    end else if (xfer) begin
                        half <= 1'b0;
                        if (state == ST_INSTR) begin
                            instr_wen   <= 1'b1;
                            instr_wadr  <= word_cnt;
                            instr_wdata <= {in_data, low_half};
                        end else begin
                            // Data addresses wrap modulo the address width.
                            data_wen   <= 1'b1;
                            data_wadr  <= cfg_regs[2] + word_cnt;
                            data_wdata <= {in_data, low_half};
                        end
                        if (last_word) begin
                            word_cnt <= '0;
                            if (state == ST_INSTR) begin
                                instr_done <= 1'b1;
                                state      <= ST_DATA;
                            end else begin
                                batch_done <= 1'b1;
                                in_rdy     <= 1'b0;
                                state      <= ST_WAIT;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (batch_ack) begin
                        batch_done <= 1'b0;
                        in_rdy     <= 1'b1;
                        state      <= ST_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_stream_loader.sv
// Bench for io_stream_loader: a transaction-level model predicts flags, config values and
// the exact cycle, address and data of every memory write; literal checks pin the model.
module tb_io_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] instr_max_wadr, input_max_wadr, input_wadr_offset, output_max_adr, output_adr_offset;
    logic        config_done, instr_wen, data_wen, instr_done, batch_done;
    logic        batch_ack = 1'b0;
    logic [15:0] instr_wadr, data_wadr;
    logic [31:0] instr_wdata, data_wdata;

    io_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .instr_max_wadr(instr_max_wadr), .input_max_wadr(input_max_wadr),
        .input_wadr_offset(input_wadr_offset), .output_max_adr(output_max_adr),
        .output_adr_offset(output_adr_offset), .config_done(config_done),
        .instr_wen(instr_wen), .instr_wadr(instr_wadr), .instr_wdata(instr_wdata),
        .data_wen(data_wen), .data_wadr(data_wadr), .data_wdata(data_wdata),
        .instr_done(instr_done), .batch_done(batch_done), .batch_ack(batch_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        bit          instr;
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] seen_instr[$];
    logic [15:0] seen_data[$];
    int          n_instr = 0;
    int          n_data = 0;

    // Model state, updated once per accepted transfer.
    int          m_phase;          // 0 config, 1 instr, 2 data, 3 waiting for ack
    int          m_cnt;
    int          m_words;
    bit          m_half;
    logic [15:0] m_low;
    logic [15:0] m_cfg[5];
    bit          m_rdy, m_cfg_done, m_instr_done, m_batch_done;

    task automatic fail_line(input string nm, input logic [63:0] got, input logic [63:0] want);
        failures++;
        $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) fail_line(nm, got, want);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_words = 0; m_half = 0; m_low = '0;
        for (int i = 0; i < 5; i++) m_cfg[i] = '0;
        m_rdy = 0; m_cfg_done = 0; m_instr_done = 0; m_batch_done = 0;
        expq.delete();
    endtask

    task automatic model_xfer(input logic [15:0] d);
        exp_t e;
        logic [15:0] lim;
        if (m_phase == 0) begin
            m_cfg[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 5) begin
                m_cfg_done = 1; m_cnt = 0; m_phase = 1; m_half = 0; m_words = 0;
            end
        end else if (!m_half) begin
            m_low = d; m_half = 1;
        end else begin
            m_half = 0;
            e.cyc = cyc;
            e.instr = (m_phase == 1);
            e.a = (m_phase == 1) ? 16'(m_words) : 16'(m_cfg[2] + 16'(m_words));
            e.d = {d, m_low};
            expq.push_back(e);
            lim = (m_phase == 1) ? m_cfg[0] : m_cfg[1];
            if (m_words == int'(lim)) begin
                m_words = 0;
                if (m_phase == 1) begin
                    m_instr_done = 1; m_phase = 2;
                end else begin
                    m_batch_done = 1; m_rdy = 0; m_phase = 3;
                end
            end else begin
                m_words++;
            end
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    exp_t ce;
    always @(negedge clk) begin
        #1;
        checks++;
        if ({in_rdy, config_done, instr_done, batch_done} !== {m_rdy, m_cfg_done, m_instr_done, m_batch_done})
            fail_line("flags rdy/cfg/instr/batch", {in_rdy, config_done, instr_done, batch_done},
                      {m_rdy, m_cfg_done, m_instr_done, m_batch_done});
        checks++;
        if ({instr_max_wadr, input_max_wadr, input_wadr_offset, output_max_adr} !== {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]}
            || output_adr_offset !== m_cfg[4])
            fail_line("config_regs", {instr_max_wadr, input_max_wadr, input_wadr_offset, output_max_adr},
                      {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]});
        if (instr_wen || data_wen) begin
            checks++;
            if (expq.size() == 0) begin
                fail_line("unexpected_write", {instr_wen, data_wen}, 0);
            end else begin
                ce = expq.pop_front();
                if (ce.cyc != cyc || instr_wen == data_wen || ce.instr != instr_wen)
                    fail_line("write_timing", 64'(cyc), 64'(ce.cyc));
                else if ((instr_wen ? instr_wadr : data_wadr) !== ce.a || (instr_wen ? instr_wdata : data_wdata) !== ce.d)
                    fail_line("write_addr_data", {instr_wen ? instr_wadr : data_wadr, instr_wen ? instr_wdata : data_wdata},
                              {ce.a, ce.d});
            end
            if (instr_wen) begin n_instr++; seen_instr.push_back(instr_wadr); end
            if (data_wen) begin n_data++; seen_data.push_back(data_wadr); end
        end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            checks++;
            fail_line("missing_write", 64'(cyc), 64'(expq[0].cyc));
            void'(expq.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [15:0] d);
        int n = 0;
        in_data = d;
        in_vld = 1'b1;
        while (!in_rdy && n < 100) begin @(negedge clk); n++; end
        if (!in_rdy) begin
            checks++;
            fail_line("send_timeout", 0, 1);
            in_vld = 1'b0;
            return;
        end
        @(negedge clk);
        in_vld = 1'b0;
        model_xfer(d);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        send(w[15:0]);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        send(w[31:16]);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_vld = 1'b0; batch_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_rdy = 1;
    endtask

    task automatic load_cfg(input logic [15:0] c0, c1, c2, c3, c4);
        send(c0); send(c1); send(c2); send(c3); send(c4);
    endtask

    task automatic ack_batch();
        batch_ack = 1'b1;
        @(negedge clk);
        batch_ack = 1'b0;
        m_batch_done = 0; m_rdy = 1; m_phase = 2;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #2;
        chk("reset_in_rdy", in_rdy, 0);
        chk("reset_dones", {config_done, instr_done, batch_done}, 0);
        chk("reset_wen", {instr_wen, data_wen}, 0);
        chk("reset_wadr_wdata", {instr_wadr, data_wadr, instr_wdata, data_wdata}, 0);
        chk("reset_cfg", {instr_max_wadr, input_wadr_offset, output_adr_offset}, 0);
        @(negedge clk);
        do_reset();

        load_cfg(16'd125, 16'd23, 16'h07d0, 16'd23, 16'h07e8);
        #2;
        chk("cfg_instr_max", instr_max_wadr, 125);
        chk("cfg_input_max", input_max_wadr, 23);
        chk("cfg_offset", input_wadr_offset, 16'h07d0);
        chk("cfg_out_max", output_max_adr, 23);
        chk("cfg_out_off", output_adr_offset, 16'h07e8);
        chk("config_done", config_done, 1);

        @(negedge clk);
        for (int i = 0; i < 126; i++) send_word({16'hA000 + 16'(i), 16'h5000 + 16'(i)}, 0);
        #2;
        chk("instr_count", n_instr, 126);
        chk("instr_last_addr", seen_instr[125], 125);
        chk("instr_done", instr_done, 1);
        chk("no_data_yet", n_data, 0);

        @(negedge clk);
        for (int j = 0; j < 24; j++) send_word({16'hD000 + 16'(j), 16'hC000 + 16'(j)}, 0);
        #2;
        chk("batch_first_addr", seen_data[0], 16'h07d0);
        chk("batch_last_addr", seen_data[23], 16'h07e7);
        chk("batch_done_rdy", {batch_done, in_rdy}, 2'b10);

        @(negedge clk);
        in_data = 16'h1234;
        in_vld = 1'b1;
        repeat (10) @(negedge clk);
        in_vld = 1'b0;
        #2;
        chk("held_no_writes", n_data, 24);
        chk("held_rdy_low", in_rdy, 0);
        @(negedge clk);
        ack_batch();
        seen_data.delete();
        for (int j = 0; j < 4; j++) send_word({16'hE000 + 16'(j), 16'hB000 + 16'(j)}, 0);
        #2;
        chk("after_ack_addr", seen_data[0], 16'h07d0);
        @(negedge clk);
        for (int j = 4; j < 24; j++) send_word({16'hE000 + 16'(j), 16'hB000 + 16'(j)}, 3);
        #2;
        chk("gap_batch_done", batch_done, 1);
        chk("gap_last_addr", seen_data[23], 16'h07e7);
        @(negedge clk);
        ack_batch();

        do_reset();
        load_cfg(16'd11, 16'd3, 16'hFFFE, 16'd5, 16'd6);
        for (int i = 0; i < 10; i++) send_word({16'h7000 + 16'(i), 16'h3000 + 16'(i)}, 1);
        send(16'h300A);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_outputs", {in_rdy, config_done, instr_done, batch_done, instr_wen, data_wen}, 0);
        chk("midrst_cfg", {instr_max_wadr, input_max_wadr, input_wadr_offset}, 0);
        chk("midrst_wadr", {instr_wadr, instr_wdata}, 0);
        @(negedge clk);
        do_reset();
        seen_instr.delete();
        seen_data.delete();
        load_cfg(16'd11, 16'd3, 16'hFFFE, 16'd5, 16'd6);
        for (int i = 0; i < 12; i++) send_word({16'h7000 + 16'(i), 16'h3000 + 16'(i)}, 1);
        #2;
        chk("reload_first_addr", seen_instr[0], 0);
        chk("reload_instr_done", {instr_done, 4'(seen_instr.size())}, {1'b1, 4'd12});
        @(negedge clk);
        for (int j = 0; j < 4; j++) send_word({16'h9000 + 16'(j), 16'h8000 + 16'(j)}, 1);
        #2;
        chk("wrap_addrs", {seen_data[0], seen_data[1], seen_data[2], seen_data[3]},
            {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
        chk("wrap_batch_done", batch_done, 1);
        chk("wrap_no_pending", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_stream_loader.md
# io_stream_loader

Input-side loader sitting directly behind the user-project IO pads, ahead of the accelerator core. It accepts the 16-bit pad input stream, captures the five configuration words, and assembles 16-bit half-words into 32-bit words. Assembled instructions go to the instruction memory write port; data goes to the data memory write port. Data is handed to the core in batches under a done/ack handshake.

## Interface

Parameters:
- IN_WIDTH, 16, pad input word width
- WORD_WIDTH, 32, assembled memory word width (2 × IN_WIDTH)
- ADDR_WIDTH, 16, memory address width
- NUM_CONFIGS, 5, configuration words loaded after reset

Ports:
- clk  input  1  core clock (pad io_in[19])
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  IN_WIDTH  pad input word (io_in[16:1])
- in_vld  input  1  pad input valid (io_in[17])
- in_rdy  output  1  loader can accept (drives io_out[29])
- instr_max_wadr  output  ADDR_WIDTH  config word 0
- input_max_wadr  output  ADDR_WIDTH  config word 1
- input_wadr_offset  output  ADDR_WIDTH  config word 2
- output_max_adr  output  ADDR_WIDTH  config word 3
- output_adr_offset  output  ADDR_WIDTH  config word 4
- config_done  output  1  level; all config words captured
- instr_wen  output  1  instruction memory write strobe
- instr_wadr  output  ADDR_WIDTH  instruction write address
- instr_wdata  output  WORD_WIDTH  instruction write data
- data_wen  output  1  data memory write strobe
- data_wadr  output  ADDR_WIDTH  data write address
- data_wdata  output  WORD_WIDTH  data write data
- instr_done  output  1  level; instruction load finished
- batch_done  output  1  level; one data batch written, waiting for ack
- batch_ack  input  1  core has consumed the batch

## Operation

- Transfer: occurs on a rising clk when in_vld && in_rdy. No other cycle changes state.
- States: CFG → INSTR → DATA ⇄ WAIT.
- CFG: each transfer writes in_data to config register cfg_cnt, then cfg_cnt increments. After transfer NUM_CONFIGS−1: set config_done, clear counters, enter INSTR.
- INSTR:
  - Half-word toggle `half` starts at 0. The first transfer (half=0) latches the low half. The second transfer (half=1) forms {in_data, low}.
  - On the second transfer, issue a write: instr_wadr = word count, then increment word count.
  - After the write at address instr_max_wadr: set instr_done, clear the word count and half, enter DATA.
- DATA:
  - Half-word assembly is identical to INSTR.
  - data_wadr = input_wadr_offset + word count, truncated to ADDR_WIDTH (wraps).
  - After the write at word count input_max_wadr: set batch_done, clear the word count, enter WAIT.
- WAIT:
  - in_rdy = 0.
  - On batch_ack = 1: clear batch_done and return to DATA. The next batch starts at offset + 0.
  - batch_ack in any other state is ignored.
- The half toggle is never cleared by an idle in_vld. Gaps between halves or words are legal and change nothing.
- A max value of 0 means a one-word region.
- All config registers stay stable after CFG until reset.

## Timing

- Reset values: in_rdy 0, all config outputs 0, config_done 0, instr_done 0, batch_done 0, all wen 0, all wadr/wdata 0. State CFG, counters 0, half 0.
- in_rdy rises on the first clk edge after rst_n deasserts. It stays 1 in CFG/INSTR/DATA and drops on the same edge that enters WAIT.
- Config register: updated on the transfer edge, so it is visible the next cycle.
- Memory writes are registered. instr_wen/data_wen pulse high for exactly one cycle, starting the cycle after the second-half transfer, with wadr/wdata valid in that cycle.
- Back-to-back transfers give at most one write every 2 cycles.
- config_done, instr_done and batch_done rise on the edge of the final transfer.
- The final write of a region, and batch_done, are visible in the same cycle.
- WAIT → DATA: the edge sampling batch_ack = 1 clears batch_done and raises in_rdy.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any partial half-word is discarded, and loading restarts at CFG.

## Test plan

- Config load:
  - Stimulus: stream 125, 23, 0x07d0, 23, 0x07e8 with in_vld continuous.
  - Required: config outputs hold those values, and config_done rises after the 5th transfer.
- Instruction load:
  - Stimulus: 126 words sent as low/high halves, word i = {16'hA000+i, 16'h5000+i}.
  - Required: exactly 126 instr_wen pulses, addresses 0..125, wdata matching. instr_done high after the last pulse; no data_wen.
- Data batch with back-pressure:
  - Stimulus: 24 words streamed, then 4 more words offered.
  - Required: data_wadr 0x07d0..0x07e7, and batch_done set with in_rdy = 0. No further writes until batch_ack is pulsed, after which the next write lands at 0x07d0.
- Valid gaps:
  - Stimulus: random idle cycles inserted between halves and between words.
  - Required: identical write sequence, and each write occurs one cycle after its high half.
- Reset mid-load:
  - Stimulus: rst_n pulsed low after the low half of instruction 10.
  - Required: outputs return to reset values immediately, and a fresh config + instruction stream loads correctly from address 0.
- Address wrap:
  - Stimulus: input_wadr_offset = 0xFFFE, input_max_wadr = 3.
  - Required: writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
